dmem_mmio: RTL and testbench

- Data-memory stage of the single-cycle MIPS datapath; consumes the ALU result as the address and rd2 as store data, and returns dmemout to the MemtoReg mux.
- Word-addressed RAM plus a small memory-mapped I/O window: free-running cycle counter, byte console TX FIFO drained by a ready/valid sink, and a status register.
- Reads are combinational (single-cycle datapath); all state updates happen on the rising clock edge.

---
 rtl/mips_pkg.sv | 16 +
 rtl/tx_fifo.sv | 51 +++++
 rtl/dmem_mmio.sv | 105 ++++++++++
 tb/tb_dmem_mmio.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS data-memory stage: the MMIO page, register offsets and
// STATUS bit positions.
package mips_pkg;

    localparam logic [15:0] MMIO_PAGE  = 16'hFFFF;

    localparam logic [15:0] CYCLE_OFF  = 16'h0000;
    localparam logic [15:0] TXDATA_OFF = 16'h0004;
    localparam logic [15:0] STATUS_OFF = 16'h0008;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 3;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the console sink. A push to a full FIFO is taken only when a pop frees
// a slot in the same cycle; the head reads as zero while empty.
module tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    din,
    output logic                          full,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign count   = count_q;
    assign dout    = empty ? 8'h00 : mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM with combinational loads plus an MMIO page holding a cycle
// counter, a console TX FIFO and a status register.
module dmem_mmio
    import mips_pkg::*;
#(
    parameter int unsigned AW         = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wrdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rddata,
    output logic        misalign,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [2**AW];
    logic [31:0]   cycle_q;
    logic          ovf_q;
    logic          ovf_d;

    logic          aligned;
    logic          is_mmio;
    logic [15:0]   offset;
    logic          wr_ok;
    logic          push;
    logic          ovf_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    assign aligned  = (addr[1:0] == 2'b00);
    assign is_mmio  = (addr[31:16] == MMIO_PAGE);
    assign offset   = addr[15:0];
    assign misalign = (MemRead || MemWrite) && !aligned;
    assign wr_ok    = MemWrite && aligned;
    assign push     = wr_ok && is_mmio && (offset == TXDATA_OFF);
    assign ovf_clr  = wr_ok && is_mmio && (offset == STATUS_OFF) && wrdata[ST_OVF];
    assign tx_valid = !fifo_empty;

    // A dropped push (full, no simultaneous pop) outranks a clear in the same cycle.
    assign ovf_d = (push && fifo_full && !(tx_valid && tx_ready)) || (ovf_q && !ovf_clr);

    always_comb begin
        status                             = '0;
        status[ST_EMPTY]                   = fifo_empty;
        status[ST_FULL]                    = fifo_full;
        status[ST_OVF]                     = ovf_q;
        status[ST_CNT_LSB +: CW]           = fifo_count;
    end

    always_comb begin
        rddata = '0;
        if (MemRead && aligned) begin
            if (is_mmio) begin
                unique case (offset)
                    CYCLE_OFF:  rddata = cycle_q;
                    STATUS_OFF: rddata = status;
                    default:    rddata = '0;
                endcase
            end else begin
                rddata = ram_q[addr[AW+1:2]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && wr_ok && !is_mmio) begin
            ram_q[addr[AW+1:2]] <= wrdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            ovf_q   <= ovf_d;
        end
    end

    tx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (wrdata[7:0]),
        .full  (fifo_full),
        .pop   (tx_ready),
        .dout  (tx_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: table of RAM/decode vectors plus hand sequences for the
// cycle counter, reset and TX FIFO behaviour.
module tb_dmem_mmio;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rddata;
    logic        misalign;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] d;
        logic        mr;
        logic        mw;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t     vecs[$];
    logic [7:0] rx[$];

    dmem_mmio #(
        .AW(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .wrdata   (wrdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .rddata   (rddata),
        .misalign (misalign),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic mr,
                           input logic mw);
        addr     = a;
        wrdata   = d;
        MemRead  = mr;
        MemWrite = mw;
        #2;
    endtask

    task automatic drain(input string name, input int exp_n);
        rx.delete();
        tx_ready = 1'b1;
        set_bus(32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) rx.push_back(tx_data);
            else if (rx.size() > 0) break;
            tick();
            #2;
        end
        tx_ready = 1'b0;
        chk({name, "_rx_count"}, rx.size(), exp_n);
    endtask

    task automatic push_byte(input logic [7:0] b);
        set_bus(32'hFFFF_0004, {24'h0, b}, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        reset    = 1'b0;
        tx_ready = 1'b0;
        addr     = '0;
        wrdata   = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        tick();
        tick();
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("reset_status", rddata, 32'h1);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        reset = 1'b1;

        // Counter: ten edges after release
        repeat (10) tick();
        set_bus(32'hFFFF_0000, 32'h0, 1'b1, 1'b0);
        chk("cycle_10", rddata, 32'd10);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_bus(32'hFFFF_0000, 32'h0, 1'b1, 1'b0);
        chk("cycle_after_reset", rddata, 32'd0);
        tick();

        vecs.push_back('{"st_init",    32'h0000_0010, 32'h1111_1111, 1'b0, 1'b1, 32'h0, 1'b0});
        vecs.push_back('{"st_old_rd",  32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1,
                         32'h1111_1111, 1'b0});
        vecs.push_back('{"ld_new",     32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"ld_alias",   32'h0000_0410, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"ld_alias_hi", 32'h0001_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"ld_fffe",    32'hFFFE_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"ld_mis",     32'h0000_0012, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{"st_mis",     32'h0000_0013, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h0, 1'b1});
        vecs.push_back('{"st_mis_rd",  32'h0000_0011, 32'h0BAD_0BAD, 1'b1, 1'b1, 32'h0, 1'b1});
        vecs.push_back('{"ld_kept",    32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"st_14",      32'h0000_0014, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0, 1'b0});
        vecs.push_back('{"ld_14",      32'h0000_0014, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{"ld_10_again", 32'h0000_0010, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"no_memread", 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"ld_unmapped", 32'hFFFF_000C, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"st_unmapped", 32'hFFFF_0010, 32'h0000_0123, 1'b0, 1'b1, 32'h0, 1'b0});
        vecs.push_back('{"ld_txdata",  32'hFFFF_0004, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"st_tx_mis",  32'hFFFF_0005, 32'h0000_0077, 1'b0, 1'b1, 32'h0, 1'b1});
        vecs.push_back('{"status_idle", 32'hFFFF_0008, 32'h0, 1'b1, 1'b0, 32'h1, 1'b0});

        foreach (vecs[i]) begin
            set_bus(vecs[i].a, vecs[i].d, vecs[i].mr, vecs[i].mw);
            chk({vecs[i].name, "_rd"}, rddata, vecs[i].exp_rd);
            chk({vecs[i].name, "_mis"}, {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
            tick();
        end

        // Fill past full with the sink stalled
        push_byte(8'h41);
        set_bus(32'h0, 32'h0, 1'b0, 1'b0);
        chk("tx_first_valid", {31'h0, tx_valid}, 32'h1);
        push_byte(8'h42);
        push_byte(8'h43);
        push_byte(8'h44);
        push_byte(8'h45);
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("status_full_ovf", rddata, 32'h26);
        chk("tx_head_held", {24'h0, tx_data}, 32'h41);
        drain("drain1", 4);
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            chk($sformatf("drain1_byte%0d", i), {24'h0, rx[i]}, 32'h41 + i);
        end
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("status_empty_ovf", rddata, 32'h5);
        tick();
        set_bus(32'hFFFF_0008, 32'h0000_0004, 1'b0, 1'b1);
        tick();
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("status_ovf_clr", rddata, 32'h1);
        tick();

        // Empty FIFO: no bypass even with the sink ready
        tx_ready = 1'b1;
        set_bus(32'hFFFF_0004, 32'h0000_0055, 1'b0, 1'b1);
        chk("no_bypass_valid", {31'h0, tx_valid}, 32'h0);
        tick();
        set_bus(32'h0, 32'h0, 1'b0, 1'b0);
        chk("bypass_next_valid", {31'h0, tx_valid}, 32'h1);
        chk("bypass_next_data", {24'h0, tx_data}, 32'h55);
        tick();
        tx_ready = 1'b0;
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("after_pop_status", rddata, 32'h1);
        tick();

        // Full FIFO with a pop in the same cycle as a push
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        tx_ready = 1'b1;
        set_bus(32'hFFFF_0004, 32'h0000_0005, 1'b0, 1'b1);
        tick();
        tx_ready = 1'b0;
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("full_push_pop_status", rddata, 32'h22);
        chk("full_push_pop_head", {24'h0, tx_data}, 32'h02);
        drain("drain2", 4);
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            chk($sformatf("drain2_byte%0d", i), {24'h0, rx[i]}, 32'h02 + i);
        end
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("drain2_status", rddata, 32'h1);
        tick();

        // Reset with data queued and overflow set
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        push_byte(8'h64);
        push_byte(8'h65);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_bus(32'hFFFF_0008, 32'h0, 1'b1, 1'b0);
        chk("mid_reset_status", rddata, 32'h1);
        chk("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_reset_tx_data", {24'h0, tx_data}, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
